// File: rtl/wb_arbiter_2m.sv
// Two-master / one-slave Wishbone arbiter placed in front of the 16-bit BRAM.
// Master 0 is the DCPU16 instruction-fetch port and master 1 is the data/DMA port.
// A request is granted one cycle after it is seen.
// A grant stays with its master for as long as that master holds cyc.
// When both masters request together, the priority bit chooses the winner round-robin.
// A watchdog changes a slave access that never terminates into a master-side err.
module wb_arbiter_2m #(
    parameter int AW      = 17,
    parameter int DW      = 17,
    parameter int TIMEOUT = 64
) (
    input  logic          clk,
    input  logic          rst,

    input  logic [AW-1:0] m0_adr,
    input  logic [DW-1:0] m0_din,
    output logic [DW-1:0] m0_dout,
    input  logic          m0_cyc,
    input  logic          m0_stb,
    input  logic [1:0]    m0_sel,
    input  logic          m0_we,
    output logic          m0_ack,
    output logic          m0_err,
    output logic          m0_rty,

    input  logic [AW-1:0] m1_adr,
    input  logic [DW-1:0] m1_din,
    output logic [DW-1:0] m1_dout,
    input  logic          m1_cyc,
    input  logic          m1_stb,
    input  logic [1:0]    m1_sel,
    input  logic          m1_we,
    output logic          m1_ack,
    output logic          m1_err,
    output logic          m1_rty,

    output logic [AW-1:0] s_adr,
    output logic [DW-1:0] s_din,
    input  logic [DW-1:0] s_dout,
    output logic          s_cyc,
    output logic          s_stb,
    output logic [1:0]    s_sel,
    output logic          s_we,
    input  logic          s_ack,
    input  logic          s_err,
    input  logic          s_rty
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        GNT0 = 2'd1,
        GNT1 = 2'd2
    } state_t;

    localparam logic [7:0] TIMEOUT_8 = 8'(TIMEOUT);

    state_t     state;
    logic       pri;
    logic [7:0] wdc;
    logic       wd_fire;
    logic       term;

    assign term = s_ack | s_err | s_rty;

    // The watchdog fires when the counter reaches the limit.
    // A limit of zero switches the watchdog off completely.
    always_comb begin
        wd_fire = 1'b0;
        if (TIMEOUT != 0 && wdc == TIMEOUT_8)
            wd_fire = 1'b1;
    end

    // Grant FSM: round-robin choice from IDLE, then lock on the winner until it drops cyc.
    // Releasing a grant hands priority to the other master.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            pri   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (m0_cyc && m1_cyc)
                        state <= pri ? GNT1 : GNT0;
                    else if (m0_cyc)
                        state <= GNT0;
                    else if (m1_cyc)
                        state <= GNT1;
                end
                GNT0: begin
                    if (!m0_cyc) begin
                        state <= IDLE;
                        pri   <= 1'b1;
                    end
                end
                GNT1: begin
                    if (!m1_cyc) begin
                        state <= IDLE;
                        pri   <= 1'b0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Watchdog counter: counts cycles in which an access is strobed but not yet terminated.
    // It restarts on any termination, on a gap in stb, or when the grant is lost.
    // A gap in stb includes the cycle in which the watchdog suppresses stb itself.
    always_ff @(posedge clk) begin
        if (rst)
            wdc <= 8'd0;
        else if (TIMEOUT == 0)
            wdc <= 8'd0;
        else if (s_cyc && s_stb && !term)
            wdc <= wdc + 8'd1;
        else
            wdc <= 8'd0;
    end

    // Datapath mux, selected by the grant state.
    // Terminations and read data pass straight through, so they add no latency.
    // The master that holds no grant sees all zeros.
    always_comb begin
        s_adr   = '0;
        s_din   = '0;
        s_sel   = 2'b00;
        s_we    = 1'b0;
        s_cyc   = 1'b0;
        s_stb   = 1'b0;
        m0_dout = '0;
        m0_ack  = 1'b0;
        m0_err  = 1'b0;
        m0_rty  = 1'b0;
        m1_dout = '0;
        m1_ack  = 1'b0;
        m1_err  = 1'b0;
        m1_rty  = 1'b0;
        case (state)
            GNT0: begin
                s_adr   = m0_adr;
                s_din   = m0_din;
                s_sel   = m0_sel;
                s_we    = m0_we;
                s_cyc   = m0_cyc;
                s_stb   = m0_stb & ~wd_fire;
                m0_dout = s_dout;
                m0_ack  = s_ack;
                m0_err  = s_err | wd_fire;
                m0_rty  = s_rty;
            end
            GNT1: begin
                s_adr   = m1_adr;
                s_din   = m1_din;
                s_sel   = m1_sel;
                s_we    = m1_we;
                s_cyc   = m1_cyc;
                s_stb   = m1_stb & ~wd_fire;
                m1_dout = s_dout;
                m1_ack  = s_ack;
                m1_err  = s_err | wd_fire;
                m1_rty  = s_rty;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_wb_arbiter_2m.sv
// Directed bench for wb_arbiter_2m.
// One table row describes one clock cycle.
// Inputs are driven just after the rising edge, and the combinational outputs are checked on the falling edge.
// A second instance built with TIMEOUT=0 shares the same inputs so the disabled watchdog can be observed.
module tb_wb_arbiter_2m;

    localparam logic [16:0] D0 = 17'h0AAAA;
    localparam logic [16:0] D1 = 17'h15555;

    logic        clk = 1'b0;
    logic        rst;
    logic [16:0] m0_adr, m0_din, m0_dout, m1_adr, m1_din, m1_dout;
    logic        m0_cyc, m0_stb, m0_we, m0_ack, m0_err, m0_rty;
    logic        m1_cyc, m1_stb, m1_we, m1_ack, m1_err, m1_rty;
    logic [1:0]  m0_sel, m1_sel, s_sel;
    logic [16:0] s_adr, s_din, s_dout;
    logic        s_cyc, s_stb, s_we, s_ack, s_err, s_rty;

    logic [16:0] n_m0_dout, n_m1_dout, n_s_adr, n_s_din;
    logic        n_m0_ack, n_m0_err, n_m0_rty, n_m1_ack, n_m1_err, n_m1_rty;
    logic        n_s_cyc, n_s_stb, n_s_we;
    logic [1:0]  n_s_sel;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    wb_arbiter_2m #(.AW(17), .DW(17), .TIMEOUT(4)) u_dut (
        .clk(clk), .rst(rst),
        .m0_adr(m0_adr), .m0_din(m0_din), .m0_dout(m0_dout), .m0_cyc(m0_cyc), .m0_stb(m0_stb),
        .m0_sel(m0_sel), .m0_we(m0_we), .m0_ack(m0_ack), .m0_err(m0_err), .m0_rty(m0_rty),
        .m1_adr(m1_adr), .m1_din(m1_din), .m1_dout(m1_dout), .m1_cyc(m1_cyc), .m1_stb(m1_stb),
        .m1_sel(m1_sel), .m1_we(m1_we), .m1_ack(m1_ack), .m1_err(m1_err), .m1_rty(m1_rty),
        .s_adr(s_adr), .s_din(s_din), .s_dout(s_dout), .s_cyc(s_cyc), .s_stb(s_stb),
        .s_sel(s_sel), .s_we(s_we), .s_ack(s_ack), .s_err(s_err), .s_rty(s_rty)
    );

    wb_arbiter_2m #(.AW(17), .DW(17), .TIMEOUT(0)) u_dut_nowd (
        .clk(clk), .rst(rst),
        .m0_adr(m0_adr), .m0_din(m0_din), .m0_dout(n_m0_dout), .m0_cyc(m0_cyc), .m0_stb(m0_stb),
        .m0_sel(m0_sel), .m0_we(m0_we), .m0_ack(n_m0_ack), .m0_err(n_m0_err), .m0_rty(n_m0_rty),
        .m1_adr(m1_adr), .m1_din(m1_din), .m1_dout(n_m1_dout), .m1_cyc(m1_cyc), .m1_stb(m1_stb),
        .m1_sel(m1_sel), .m1_we(m1_we), .m1_ack(n_m1_ack), .m1_err(n_m1_err), .m1_rty(n_m1_rty),
        .s_adr(n_s_adr), .s_din(n_s_din), .s_dout(s_dout), .s_cyc(n_s_cyc), .s_stb(n_s_stb),
        .s_sel(n_s_sel), .s_we(n_s_we), .s_ack(s_ack), .s_err(s_err), .s_rty(s_rty)
    );

    // ctl  = {rst, m0_cyc, m0_stb, m0_we, m1_cyc, m1_stb, s_ack, s_err, s_rty}
    // ectl = {s_cyc, s_stb, s_we, m0_ack, m0_err, m0_rty, m1_ack, m1_err, m1_rty}
    typedef struct {
        logic [8:0]  ctl;
        logic [16:0] sdout;
        logic [16:0] a0;
        logic [16:0] a1;
        logic [8:0]  ectl;
        logic [16:0] eadr;
        logic [16:0] edin;
        logic [1:0]  esel;
        logic [16:0] ed0;
        logic [16:0] ed1;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mkv(input logic [8:0] ctl, input logic [16:0] sdout,
                                 input logic [16:0] a0, input logic [16:0] a1,
                                 input logic [8:0] ectl, input logic [16:0] eadr,
                                 input logic [16:0] edin, input logic [1:0] esel,
                                 input logic [16:0] ed0, input logic [16:0] ed1);
        vec_t v;
        v.ctl = ctl;  v.sdout = sdout; v.a0 = a0;     v.a1 = a1;
        v.ectl = ectl; v.eadr = eadr;  v.edin = edin; v.esel = esel;
        v.ed0 = ed0;  v.ed1 = ed1;
        return v;
    endfunction

    task automatic applyStimulus(input vec_t v);
        @(posedge clk);
        #1;
        {rst, m0_cyc, m0_stb, m0_we, m1_cyc, m1_stb, s_ack, s_err, s_rty} = v.ctl;
        s_dout = v.sdout;
        m0_adr = v.a0;
        m1_adr = v.a1;
    endtask

    task automatic checkOutput(input int idx, input vec_t v);
        logic [78:0] act;
        logic [78:0] exp;
        @(negedge clk);
        act = {s_cyc, s_stb, s_we, m0_ack, m0_err, m0_rty, m1_ack, m1_err, m1_rty,
               s_adr, s_din, s_sel, m0_dout, m1_dout};
        exp = {v.ectl, v.eadr, v.edin, v.esel, v.ed0, v.ed1};
        tests++;
        if (act !== exp) begin
            fails++;
            $display("[TB] FAIL row%0d: got %h expected %h", idx, act, exp);
        end
    endtask

    task automatic checkCount(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("[TB] FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    initial begin
        int err_cnt;
        int n_err_cnt;
        int n_stb_gap;

        rst = 1'b1;
        m0_adr = '0; m1_adr = '0; m0_din = D0; m1_din = D1;
        m0_cyc = 0; m0_stb = 0; m0_we = 0; m0_sel = 2'b11;
        m1_cyc = 0; m1_stb = 0; m1_we = 0; m1_sel = 2'b01;
        s_dout = '0; s_ack = 0; s_err = 0; s_rty = 0;
        repeat (2) @(posedge clk);

        // Reset, then a single read by m0; the ack arrives on the first granted cycle
        vecs.push_back(mkv(9'b1_000_00_000, 17'h0,     17'h10, 17'h0,  9'b000_000_000, 17'h0,  17'h0, 2'b00, 17'h0,     17'h0));
        vecs.push_back(mkv(9'b0_110_00_000, 17'h0,     17'h10, 17'h0,  9'b000_000_000, 17'h0,  17'h0, 2'b00, 17'h0,     17'h0));
        vecs.push_back(mkv(9'b0_110_00_100, 17'h1ABCD, 17'h10, 17'h0,  9'b110_100_000, 17'h10, D0,    2'b11, 17'h1ABCD, 17'h0));
        // cyc drops in the same cycle as an ack; the ack still reaches m0
        vecs.push_back(mkv(9'b0_000_00_100, 17'h00055, 17'h10, 17'h0,  9'b000_100_000, 17'h10, D0,    2'b11, 17'h00055, 17'h0));
        vecs.push_back(mkv(9'b1_000_00_000, 17'h0,     17'h0,  17'h0,  9'b000_000_000, 17'h0,  17'h0, 2'b00, 17'h0,     17'h0));
        // Contention after reset: m0 wins, then m1 wins the repeated contention
        vecs.push_back(mkv(9'b0_110_11_000, 17'h0,     17'h20, 17'h30, 9'b000_000_000, 17'h0,  17'h0, 2'b00, 17'h0,     17'h0));
        vecs.push_back(mkv(9'b0_110_11_000, 17'h0,     17'h20, 17'h30, 9'b110_000_000, 17'h20, D0,    2'b11, 17'h0,     17'h0));
        vecs.push_back(mkv(9'b0_000_11_000, 17'h0,     17'h20, 17'h30, 9'b000_000_000, 17'h20, D0,    2'b11, 17'h0,     17'h0));
        vecs.push_back(mkv(9'b0_110_11_000, 17'h0,     17'h20, 17'h30, 9'b000_000_000, 17'h0,  17'h0, 2'b00, 17'h0,     17'h0));
        vecs.push_back(mkv(9'b0_110_11_100, 17'h00123, 17'h20, 17'h30, 9'b110_000_100, 17'h30, D1,    2'b01, 17'h0,     17'h00123));
        vecs.push_back(mkv(9'b0_110_00_000, 17'h0,     17'h20, 17'h30, 9'b000_000_000, 17'h30, D1,    2'b01, 17'h0,     17'h0));
        // Bus lock: three writes by m0 while m1 keeps requesting
        vecs.push_back(mkv(9'b0_111_11_000, 17'h0,     17'h4,  17'h30, 9'b000_000_000, 17'h0,  17'h0, 2'b00, 17'h0,     17'h0));
        vecs.push_back(mkv(9'b0_111_11_100, 17'h0,     17'h4,  17'h30, 9'b111_100_000, 17'h4,  D0,    2'b11, 17'h0,     17'h0));
        vecs.push_back(mkv(9'b0_111_11_100, 17'h0,     17'h5,  17'h30, 9'b111_100_000, 17'h5,  D0,    2'b11, 17'h0,     17'h0));
        vecs.push_back(mkv(9'b0_111_11_100, 17'h0,     17'h6,  17'h30, 9'b111_100_000, 17'h6,  D0,    2'b11, 17'h0,     17'h0));
        vecs.push_back(mkv(9'b0_000_11_000, 17'h0,     17'h6,  17'h30, 9'b000_000_000, 17'h6,  D0,    2'b11, 17'h0,     17'h0));
        vecs.push_back(mkv(9'b0_000_11_000, 17'h0,     17'h6,  17'h30, 9'b000_000_000, 17'h0,  17'h0, 2'b00, 17'h0,     17'h0));
        vecs.push_back(mkv(9'b0_000_11_001, 17'h0,     17'h6,  17'h30, 9'b110_000_001, 17'h30, D1,    2'b01, 17'h0,     17'h0));
        // Watchdog at 4: stb rises, no termination, fire on the fifth strobed cycle together with a late ack
        vecs.push_back(mkv(9'b0_000_10_000, 17'h0,     17'h6,  17'h30, 9'b100_000_000, 17'h30, D1,    2'b01, 17'h0,     17'h0));
        vecs.push_back(mkv(9'b0_000_11_000, 17'h0,     17'h6,  17'h30, 9'b110_000_000, 17'h30, D1,    2'b01, 17'h0,     17'h0));
        vecs.push_back(mkv(9'b0_000_11_000, 17'h0,     17'h6,  17'h30, 9'b110_000_000, 17'h30, D1,    2'b01, 17'h0,     17'h0));
        vecs.push_back(mkv(9'b0_000_11_000, 17'h0,     17'h6,  17'h30, 9'b110_000_000, 17'h30, D1,    2'b01, 17'h0,     17'h0));
        vecs.push_back(mkv(9'b0_000_11_000, 17'h0,     17'h6,  17'h30, 9'b110_000_000, 17'h30, D1,    2'b01, 17'h0,     17'h0));
        vecs.push_back(mkv(9'b0_000_11_100, 17'h00077, 17'h6,  17'h30, 9'b100_000_110, 17'h30, D1,    2'b01, 17'h0,     17'h00077));
        // Reset while in GNT1 with stb pending, then m0 alone is granted; rty and err pass through
        vecs.push_back(mkv(9'b1_000_11_000, 17'h0,     17'h6,  17'h30, 9'b110_000_000, 17'h30, D1,    2'b01, 17'h0,     17'h0));
        vecs.push_back(mkv(9'b0_111_00_000, 17'h0,     17'h40, 17'h30, 9'b000_000_000, 17'h0,  17'h0, 2'b00, 17'h0,     17'h0));
        vecs.push_back(mkv(9'b0_110_00_001, 17'h0,     17'h40, 17'h30, 9'b110_001_000, 17'h40, D0,    2'b11, 17'h0,     17'h0));
        vecs.push_back(mkv(9'b0_110_00_010, 17'h0,     17'h40, 17'h30, 9'b110_010_000, 17'h40, D0,    2'b11, 17'h0,     17'h0));
        vecs.push_back(mkv(9'b0_000_00_000, 17'h0,     17'h40, 17'h30, 9'b000_000_000, 17'h40, D0,    2'b11, 17'h0,     17'h0));
        vecs.push_back(mkv(9'b0_000_00_000, 17'h0,     17'h40, 17'h30, 9'b000_000_000, 17'h0,  17'h0, 2'b00, 17'h0,     17'h0));

        foreach (vecs[i]) begin
            applyStimulus(vecs[i]);
            checkOutput(i, vecs[i]);
        end

        // Long stall by m1: count err pulses with the watchdog at 4 and with the watchdog disabled
        @(posedge clk); #1;
        {rst, m0_cyc, m0_stb, m0_we, m1_cyc, m1_stb, s_ack, s_err, s_rty} = 9'b1_000_00_000;
        @(posedge clk); #1;
        rst = 1'b0; m1_cyc = 1'b1; m1_stb = 1'b1;
        @(posedge clk); #1;
        err_cnt = 0; n_err_cnt = 0; n_stb_gap = 0;
        for (int c = 0; c < 70; c++) begin
            @(negedge clk);
            if (m1_err) err_cnt++;
            if (n_m1_err || n_m0_err) n_err_cnt++;
            if (!(n_s_cyc && n_s_stb)) n_stb_gap++;
        end
        checkCount("wd4_err_pulses", err_cnt, 14);
        checkCount("wd0_err_pulses", n_err_cnt, 0);
        checkCount("wd0_stb_gaps", n_stb_gap, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
